// File: rtl/aes_dec_arb.sv
// -----------------------------------------------------------------------------
// aes_dec_arb
//   Round-robin front end that shares one aes_dec core between NREQ clients.
//   One ciphertext/key pair is accepted at a time, launched into the core with
//   a single-cycle start pulse, and the core result (fixed 11-cycle latency) is
//   captured into a held output register tagged with the owning requester.
//   Any core result that arrives outside the expected cycle, or a missing
//   result in the expected cycle, sets a sticky error flag.
//
// Ports
//   clk, nreset     : clock, synchronous active-low reset
//   req_v_i         : per-requester request valid
//   req_ready_o     : per-requester accept (one-hot or zero, combinational)
//   req_data_i      : packed ciphertexts, requester i at [128*i +: 128]
//   req_key_i       : packed last-round keys, same packing
//   out_v_o         : held result valid
//   out_ready_i     : consumer pops the held result
//   out_data_o      : plaintext
//   out_id_o        : requester index owning out_data_o
//   core_data_v_o   : start pulse to the core
//   core_data_o     : ciphertext to the core (zero when not starting)
//   core_key_o      : key to the core (zero when not starting)
//   core_res_i      : core result
//   core_res_v_i    : core result valid
//   err_o           : sticky core timing error
// -----------------------------------------------------------------------------
module aes_dec_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [NREQ-1:0]       req_v_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*128-1:0]   req_data_i,
    input  logic [NREQ*128-1:0]   req_key_i,
    output logic                  out_v_o,
    input  logic                  out_ready_i,
    output logic [127:0]          out_data_o,
    output logic [IDW-1:0]        out_id_o,
    output logic                  core_data_v_o,
    output logic [127:0]          core_data_o,
    output logic [127:0]          core_key_o,
    input  logic [127:0]          core_res_i,
    input  logic                  core_res_v_i,
    output logic                  err_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0]    LAST_CNT = 4'd11;
    localparam int            SW       = IDW + 1;
    localparam logic [SW-1:0] NREQ_W   = SW'(NREQ);
    localparam logic [SW-1:0] ONE_W    = SW'(1);
    localparam logic [NREQ-1:0] ONEHOT0 = NREQ'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [IDW-1:0]    r_rr;
    logic [IDW-1:0]    r_id;
    logic              r_out_v;
    logic [127:0]      r_out_data;
    logic [IDW-1:0]    r_out_id;
    logic              r_err;

    logic [NREQ-1:0]   w_rot;
    logic              w_found;
    logic [IDW-1:0]    w_ofs;
    logic [SW-1:0]     w_sum;
    logic [SW-1:0]     w_inc;
    logic [IDW-1:0]    w_grant;
    logic [IDW-1:0]    w_rr_nxt;
    logic              w_issue;
    logic              w_res_slot;

    // Round-robin search: rotate the request vector so the pointer lands on
    // bit 0, pick the lowest set bit, then map the offset back to an index.
    always_comb begin
        w_rot   = NREQ'({req_v_i, req_v_i} >> r_rr);
        w_found = |w_rot;
        w_ofs   = '0;
        // Descending scan so the lowest set bit is the one that sticks.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_ofs = w_rot[k] ? IDW'(k) : w_ofs;
        end
        w_sum    = SW'(r_rr) + SW'(w_ofs);
        w_grant  = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : IDW'(w_sum);
        w_inc    = SW'(w_grant) + ONE_W;
        w_rr_nxt = (w_inc >= NREQ_W) ? '0 : IDW'(w_inc);
    end

    // Issue needs an idle core, a request, and room in the output register
    // by the time the result lands (empty now, or being popped now).
    assign w_issue    = (r_state == ST_IDLE) && w_found && (!r_out_v || out_ready_i);
    assign w_res_slot = (r_state == ST_BUSY) && (r_cnt == LAST_CNT);

    // Next-state and combinational handshake/start outputs.
    always_comb begin
        w_state_nxt   = r_state;
        req_ready_o   = '0;
        core_data_v_o = 1'b0;
        core_data_o   = '0;
        core_key_o    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt   = ST_BUSY;
                    req_ready_o   = ONEHOT0 << w_grant;
                    core_data_v_o = 1'b1;
                    core_data_o   = req_data_i[{w_grant, 7'd0} +: 128];
                    core_key_o    = req_key_i[{w_grant, 7'd0} +: 128];
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latency counter, round-robin pointer and in-flight tag.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_cnt <= 4'd0;
            r_rr  <= '0;
            r_id  <= '0;
        end else if (w_issue) begin
            r_cnt <= 4'd1;
            r_rr  <= w_rr_nxt;
            r_id  <= w_grant;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= w_res_slot ? 4'd0 : (r_cnt + 4'd1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Held result register; a reload in the expected slot wins over a pop.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_out_v    <= 1'b0;
            r_out_data <= '0;
            r_out_id   <= '0;
        end else if (w_res_slot && core_res_v_i) begin
            r_out_v    <= 1'b1;
            r_out_data <= core_res_i;
            r_out_id   <= r_id;
        end else if (r_out_v && out_ready_i) begin
            r_out_v <= 1'b0;
        end else begin
            r_out_v <= r_out_v;
        end
    end

    // Sticky error: result valid must coincide exactly with the expected slot;
    // a result outside it or a missing one inside it both differ.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_err <= 1'b0;
        end else if (core_res_v_i != w_res_slot) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign out_v_o    = r_out_v;
    assign out_data_o = r_out_data;
    assign out_id_o   = r_out_id;
    assign err_o      = r_err;

endmodule

// File: tb/tb_aes_dec_arb.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_arb
//   Self-checking bench for aes_dec_arb. A behavioural core model answers each
//   start pulse 11 cycles later (FIPS-197 C.1 vector plus a simple mixing
//   function for random blocks). Expected grants, ids and results come from a
//   round-robin pointer kept by the bench and the core function.
// -----------------------------------------------------------------------------
module tb_aes_dec_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic                  clk = 1'b0;
    logic                  nreset;
    logic [NREQ-1:0]       req_v_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*128-1:0]   req_data_i;
    logic [NREQ*128-1:0]   req_key_i;
    logic                  out_v_o;
    logic                  out_ready_i;
    logic [127:0]          out_data_o;
    logic [IDW-1:0]        out_id_o;
    logic                  core_data_v_o;
    logic [127:0]          core_data_o;
    logic [127:0]          core_key_o;
    logic [127:0]          core_res_i = 128'd0;
    logic                  core_res_v_i = 1'b0;
    logic                  err_o;

    logic [127:0] t_data [NREQ];
    logic [127:0] t_key  [NREQ];
    int           n_cmp;
    int           n_bad;
    int           cyc = 0;
    int           m_rr;
    int           drop_req = 0;
    int           drop_done = 0;
    int           spur_req = 0;
    int           spur_done = 0;
    logic [127:0] spur_val;

    typedef struct {
        int           due;
        logic [127:0] res;
    } job_t;
    job_t jobs[$];

    aes_dec_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .req_v_i      (req_v_i),
        .req_ready_o  (req_ready_o),
        .req_data_i   (req_data_i),
        .req_key_i    (req_key_i),
        .out_v_o      (out_v_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_id_o     (out_id_o),
        .core_data_v_o(core_data_v_o),
        .core_data_o  (core_data_o),
        .core_key_o   (core_key_o),
        .core_res_i   (core_res_i),
        .core_res_v_i (core_res_v_i),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == C1_CT && k == C1_KEY) return C1_PT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Round-robin rule: first valid requester at or after the pointer, wrapping.
    function automatic int ref_grant(input int rr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    // Behavioural core: fixed 11-cycle latency, reset by nreset, with hooks
    // to swallow one result or inject one spurious result.
    always begin
        logic rst_seen;
        job_t j;
        @(posedge clk);
        cyc = cyc + 1;
        rst_seen = (nreset === 1'b0);
        #1;
        core_res_v_i = 1'b0;
        core_res_i   = 128'd0;
        if (rst_seen) begin
            jobs.delete();
        end else begin
            if (jobs.size() > 0 && jobs[0].due == cyc) begin
                j = jobs.pop_front();
                if (drop_req != drop_done) begin
                    drop_done = drop_done + 1;
                end else begin
                    core_res_v_i = 1'b1;
                    core_res_i   = j.res;
                end
            end
            if (spur_req != spur_done) begin
                spur_done    = spur_done + 1;
                core_res_v_i = 1'b1;
                core_res_i   = spur_val;
            end
        end
        @(negedge clk);
        if (nreset === 1'b1 && core_data_v_o === 1'b1) begin
            j.due = cyc + 11;
            j.res = core_fn(core_data_o, core_key_o);
            jobs.push_back(j);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_data_i[128*i +: 128] = t_data[i];
            req_key_i[128*i +: 128]  = t_key[i];
        end
    endtask

    task automatic apply_reset();
        tick();
        nreset      = 1'b0;
        req_v_i     = '0;
        out_ready_i = 1'b1;
        tick();
        tick();
        nreset = 1'b1;
        m_rr   = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        neg();
        n_cmp++; if (out_v_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_v: got %b want 0", out_v_o); end
        n_cmp++; if (out_data_o !== 128'd0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data_o); end
        n_cmp++; if (out_id_o !== 2'd0) begin n_bad++; $display("FAIL reset_out_id: got %0d want 0", out_id_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready_o); end
        n_cmp++; if (core_data_v_o !== 1'b0) begin n_bad++; $display("FAIL reset_core_v: got %b want 0", core_data_v_o); end
    endtask

    task automatic test_single();
        tick();
        t_data[0] = C1_CT;
        t_key[0]  = C1_KEY;
        drive_reqs();
        req_v_i     = 4'b0001;
        out_ready_i = 1'b1;
        neg();
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready_o); end
        n_cmp++; if (core_data_v_o !== 1'b1) begin n_bad++; $display("FAIL single_core_v: got %b want 1", core_data_v_o); end
        n_cmp++; if (core_data_o !== C1_CT) begin n_bad++; $display("FAIL single_core_data: got %h want %h", core_data_o, C1_CT); end
        n_cmp++; if (core_key_o !== C1_KEY) begin n_bad++; $display("FAIL single_core_key: got %h want %h", core_key_o, C1_KEY); end
        m_rr = 1;
        tick();
        req_v_i = 4'b0000;
        neg();
        n_cmp++; if (core_data_o !== 128'd0 || core_key_o !== 128'd0) begin n_bad++; $display("FAIL single_core_zero: got %h/%h want 0/0", core_data_o, core_key_o); end
        repeat (10) tick();
        neg();
        n_cmp++; if (out_v_o !== 1'b0) begin n_bad++; $display("FAIL single_early_v: got %b want 0 at T+11", out_v_o); end
        tick();
        neg();
        n_cmp++; if (out_v_o !== 1'b1) begin n_bad++; $display("FAIL single_out_v: got %b want 1 at T+12", out_v_o); end
        n_cmp++; if (out_data_o !== C1_PT) begin n_bad++; $display("FAIL single_out_data: got %h want %h", out_data_o, C1_PT); end
        n_cmp++; if (out_id_o !== 2'd0) begin n_bad++; $display("FAIL single_out_id: got %0d want 0", out_id_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err_o); end
    endtask

    task automatic test_round_robin();
        int           g;
        int           prev_g;
        logic [127:0] prev_exp;
        prev_g   = 0;
        prev_exp = 128'd0;
        apply_reset();
        tick();
        for (int i = 0; i < NREQ; i++) begin
            t_data[i] = rand128();
            t_key[i]  = rand128();
        end
        drive_reqs();
        req_v_i     = 4'b1111;
        out_ready_i = 1'b1;
        for (int n = 0; n < 5; n++) begin
            neg();
            g = ref_grant(m_rr, req_v_i);
            n_cmp++; if (req_ready_o !== (4'b0001 << g)) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready_o, 4'b0001 << g); end
            n_cmp++; if (core_data_o !== t_data[g]) begin n_bad++; $display("FAIL rr_core_data%0d: got %h want %h", n, core_data_o, t_data[g]); end
            if (n > 0) begin
                n_cmp++; if (out_v_o !== 1'b1 || out_id_o !== prev_g[IDW-1:0] || out_data_o !== prev_exp) begin
                    n_bad++; $display("FAIL rr_result%0d: got v=%b id=%0d %h want v=1 id=%0d %h", n, out_v_o, out_id_o, out_data_o, prev_g, prev_exp);
                end
            end
            prev_g   = g;
            prev_exp = core_fn(t_data[g], t_key[g]);
            m_rr     = (g + 1) % NREQ;
            tick();
            t_data[g] = rand128();
            t_key[g]  = rand128();
            drive_reqs();
            if (n == 4) req_v_i = 4'b0000;
            neg();
            n_cmp++; if (req_ready_o !== 4'b0000) begin n_bad++; $display("FAIL rr_busy_ready%0d: got %b want 0000", n, req_ready_o); end
            repeat (11) tick();
        end
        neg();
        n_cmp++; if (out_v_o !== 1'b1 || out_id_o !== prev_g[IDW-1:0] || out_data_o !== prev_exp) begin
            n_bad++; $display("FAIL rr_result_last: got v=%b id=%0d %h want v=1 id=%0d %h", out_v_o, out_id_o, out_data_o, prev_g, prev_exp);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp0;
        logic [127:0] exp1;
        int           stall;
        tick();
        out_ready_i = 1'b0;
        t_data[0]   = rand128();
        t_key[0]    = rand128();
        drive_reqs();
        req_v_i = 4'b0001;
        neg();
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_bad++; $display("FAIL bp_first_ready: got %b want 0001", req_ready_o); end
        exp0 = core_fn(t_data[0], t_key[0]);
        m_rr = 1;
        tick();
        t_data[1] = rand128();
        t_key[1]  = rand128();
        drive_reqs();
        req_v_i = 4'b0010;
        repeat (11) tick();
        stall = $urandom_range(3, 8);
        for (int s = 0; s <= stall; s++) begin
            neg();
            n_cmp++; if (req_ready_o !== 4'b0000 || out_v_o !== 1'b1 || out_id_o !== 2'd0 || out_data_o !== exp0) begin
                n_bad++; $display("FAIL bp_stall%0d: got ready=%b v=%b id=%0d %h want ready=0000 v=1 id=0 %h", s, req_ready_o, out_v_o, out_id_o, out_data_o, exp0);
            end
            tick();
        end
        out_ready_i = 1'b1;
        neg();
        n_cmp++; if (req_ready_o !== 4'b0010 || core_data_v_o !== 1'b1) begin n_bad++; $display("FAIL bp_pop_issue: got ready=%b v=%b want ready=0010 v=1", req_ready_o, core_data_v_o); end
        exp1 = core_fn(t_data[1], t_key[1]);
        m_rr = 2;
        tick();
        req_v_i = 4'b0000;
        neg();
        n_cmp++; if (out_v_o !== 1'b0) begin n_bad++; $display("FAIL bp_popped: got %b want 0", out_v_o); end
        repeat (11) tick();
        neg();
        n_cmp++; if (out_v_o !== 1'b1 || out_id_o !== 2'd1 || out_data_o !== exp1) begin
            n_bad++; $display("FAIL bp_result: got v=%b id=%0d %h want v=1 id=1 %h", out_v_o, out_id_o, out_data_o, exp1);
        end
    endtask

    task automatic test_missing_result();
        logic [127:0] exp3;
        tick();
        t_data[2] = rand128();
        t_key[2]  = rand128();
        drive_reqs();
        req_v_i = 4'b0100;
        neg();
        n_cmp++; if (req_ready_o !== 4'b0100) begin n_bad++; $display("FAIL miss_ready: got %b want 0100", req_ready_o); end
        drop_req = drop_req + 1;
        m_rr = 3;
        tick();
        req_v_i = 4'b0000;
        repeat (10) tick();
        neg();
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL miss_err_early: got %b want 0", err_o); end
        tick();
        t_data[3] = rand128();
        t_key[3]  = rand128();
        drive_reqs();
        req_v_i = 4'b1000;
        neg();
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL miss_err: got %b want 1", err_o); end
        n_cmp++; if (out_v_o !== 1'b0) begin n_bad++; $display("FAIL miss_out_v: got %b want 0", out_v_o); end
        n_cmp++; if (req_ready_o !== 4'b1000) begin n_bad++; $display("FAIL miss_idle_issue: got %b want 1000", req_ready_o); end
        exp3 = core_fn(t_data[3], t_key[3]);
        m_rr = 0;
        tick();
        req_v_i = 4'b0000;
        repeat (11) tick();
        neg();
        n_cmp++; if (out_v_o !== 1'b1 || out_id_o !== 2'd3 || out_data_o !== exp3 || err_o !== 1'b1) begin
            n_bad++; $display("FAIL miss_next: got v=%b id=%0d %h err=%b want v=1 id=3 %h err=1", out_v_o, out_id_o, out_data_o, err_o, exp3);
        end
    endtask

    task automatic test_spurious();
        logic [127:0] exp1;
        apply_reset();
        neg();
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL spur_err_cleared: got %b want 0", err_o); end
        tick();
        out_ready_i = 1'b0;
        t_data[1]   = rand128();
        t_key[1]    = rand128();
        drive_reqs();
        req_v_i = 4'b0010;
        exp1 = core_fn(t_data[1], t_key[1]);
        m_rr = 2;
        tick();
        req_v_i = 4'b0000;
        repeat (11) tick();
        neg();
        spur_val = rand128();
        spur_req = spur_req + 1;
        tick();
        tick();
        neg();
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL spur_err: got %b want 1", err_o); end
        n_cmp++; if (out_v_o !== 1'b1 || out_id_o !== 2'd1 || out_data_o !== exp1) begin
            n_bad++; $display("FAIL spur_out_held: got v=%b id=%0d %h want v=1 id=1 %h", out_v_o, out_id_o, out_data_o, exp1);
        end
        tick();
        out_ready_i = 1'b1;
        tick();
        neg();
        n_cmp++; if (out_v_o !== 1'b0) begin n_bad++; $display("FAIL spur_pop: got %b want 0", out_v_o); end
    endtask

    task automatic test_reset_mid();
        int           g;
        logic [127:0] exp0;
        tick();
        t_data[2] = rand128();
        t_key[2]  = rand128();
        drive_reqs();
        req_v_i = 4'b0100;
        neg();
        g = ref_grant(m_rr, req_v_i);
        n_cmp++; if (req_ready_o !== (4'b0001 << g)) begin n_bad++; $display("FAIL rmid_ready: got %b want %b", req_ready_o, 4'b0001 << g); end
        tick();
        req_v_i = 4'b0000;
        repeat (4) tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        m_rr   = 0;
        neg();
        n_cmp++; if (out_v_o !== 1'b0 || out_data_o !== 128'd0 || out_id_o !== 2'd0 || err_o !== 1'b0 || req_ready_o !== 4'b0000 || core_data_v_o !== 1'b0) begin
            n_bad++; $display("FAIL rmid_reset_vals: got v=%b %h id=%0d err=%b ready=%b cv=%b want all zero", out_v_o, out_data_o, out_id_o, err_o, req_ready_o, core_data_v_o);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            neg();
            n_cmp++; if (out_v_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL rmid_no_result%0d: got v=%b err=%b want 0/0", c, out_v_o, err_o); end
        end
        tick();
        for (int i = 0; i < NREQ; i++) begin
            t_data[i] = rand128();
            t_key[i]  = rand128();
        end
        drive_reqs();
        req_v_i = 4'b1111;
        neg();
        g = ref_grant(m_rr, req_v_i);
        n_cmp++; if (req_ready_o !== (4'b0001 << g)) begin n_bad++; $display("FAIL rmid_restart_grant: got %b want %b", req_ready_o, 4'b0001 << g); end
        exp0 = core_fn(t_data[g], t_key[g]);
        tick();
        req_v_i = 4'b0000;
        repeat (11) tick();
        neg();
        n_cmp++; if (out_v_o !== 1'b1 || out_id_o !== g[IDW-1:0] || out_data_o !== exp0) begin
            n_bad++; $display("FAIL rmid_restart_result: got v=%b id=%0d %h want v=1 id=%0d %h", out_v_o, out_id_o, out_data_o, g, exp0);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        m_rr        = 0;
        nreset      = 1'b0;
        req_v_i     = '0;
        req_data_i  = '0;
        req_key_i   = '0;
        out_ready_i = 1'b1;
        spur_val    = 128'd0;
        for (int i = 0; i < NREQ; i++) begin
            t_data[i] = 128'd0;
            t_key[i]  = 128'd0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_missing_result();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
